logic_clock_ctrl: RTL and testbench
===================================

Name: logic_clock_ctrl

Overview:
Clock-control stage sitting directly upstream of the emulated 74HC191 counters. It generates the emulated CP clock for the counter chain from the FPGA system clock. Supports free-run at four selectable rates, halt, and debounced single-step from a board push-button. It also provides one-cycle edge strobes so synchronous logic in the CLK domain can track CP edges.

Parameters:
DEB_CYC, 500000, cycles a synchronised button/switch level must be stable before it is accepted (10 ms at 50 MHz)
HALF0, 25000000, CP half-period in CLK cycles for SPEED=0 (1 Hz)
HALF1, 2500000, half-period for SPEED=1 (10 Hz)
HALF2, 250000, half-period for SPEED=2 (100 Hz)
HALF3, 25, half-period for SPEED=3 (1 MHz)
STEP_HI, 4, CP high time in CLK cycles for a single step (>=1)
CNT_W, 25, width of the shared phase/debounce counters (must hold max(DEB_CYC, HALFn))

Ports:
CLK      input   1  system clock
nRST     input   1  asynchronous active-low reset
RUN_SW   input   1  raw run/stop switch, 1 = run (asynchronous, bouncy)
STEP_BTN input   1  raw step button, 1 = pressed (asynchronous, bouncy)
HALT     input   1  synchronous halt request from emulated CPU, level
SPEED    input   2  rate select, sampled only at phase reload
CP       output  1  emulated clock to counter chain, registered
CP_RISE  output  1  one-CLK strobe in the cycle CP goes 0->1
CP_FALL  output  1  one-CLK strobe in the cycle CP goes 1->0
RUNNING  output  1  1 while in RUN state

Behaviour:
- Reset (async, nRST=0): CP=0, CP_RISE=0, CP_FALL=0, RUNNING=0, state STOP, counters cleared, debounced levels 0.
- Input conditioning: RUN_SW and STEP_BTN each pass a 2-FF synchroniser, then a debouncer. The debounced level updates only after the synchronised level differs from it for DEB_CYC consecutive cycles. Any mismatch-free cycle restarts the count. Step event = debounced STEP rising edge; one event per press.
- CP, CP_RISE, CP_FALL are registered. A strobe is high in the same cycle the new CP value first appears.
- FSM states:
  - STOP: CP=0. If run_db=1 and HALT=0 -> RUN: load phase=half(SPEED)-1, CP stays 0. Else if step event and HALT=0 -> STEP_H: CP<=1, phase=STEP_HI-1.
  - RUN: phase decrements each cycle; at phase=0 CP toggles, phase reloads from the current SPEED.
    - First rise occurs half(SPEED) cycles after entering RUN.
    - If run_db=0 or HALT=1 while CP=0, go to STOP immediately; no rise is issued.
    - While CP=1, the high phase completes, CP falls, then go to STOP. A high pulse is never truncated.
  - STEP_H: phase counts down; at 0 CP<=0 (CP_FALL), go to STEP_L with phase=STEP_HI-1.
  - STEP_L: counts down, then go to STOP. Guarantees minimum low time; step events during STEP_H/STEP_L are dropped.
- RUNNING=1 exactly in RUN state, registered with state.
- SPEED changes take effect only at the next reload; the current half-period is never altered.
- RUN_SW=1 while a step is in progress: the step completes, then RUN is entered from STOP.
- HALT=1 with no step/run: remains STOP, CP=0 indefinitely.
- Counter arithmetic unsigned CNT_W; no wrap, since reload always precedes underflow.

Decomposition:
- Shared package: state encoding (STOP, RUN, STEP_H, STEP_L), SPEED index constants.
- One natural sub-module: logic_debounce (sync + stable-count filter, parameter DEB_CYC). Instanced twice.

Test Plan:
- Overrides DEB_CYC=4, HALF3=3, STEP_HI=2. Reset, then RUN_SW=1, SPEED=3 -> RUNNING=1 after 2+4 sync/debounce cycles. First CP_RISE 3 cycles later, then CP period 6 cycles, 50% duty, strobes one cycle wide.
- STEP_BTN bounced 1-0-1-0-1 at 1-cycle spacing, then held 10 cycles, with RUN_SW=0 -> exactly one CP high pulse of 2 cycles and one CP_RISE/CP_FALL pair; CP low for >=2 cycles after.
- In RUN, assert HALT one cycle after a CP_RISE -> CP stays high for the full 3 cycles, falls, RUNNING=0. No further CP_RISE while HALT=1.
- In RUN, change SPEED 3->2 mid-high-phase -> current half-period stays 3 cycles; next phase uses HALF2.
- Pulse nRST low mid-high-phase (asynchronous, off clock edge) -> CP, strobes and RUNNING are 0 immediately; state STOP after release until a debounced run/step occurs.
- HALT=1, press step -> no CP activity. Release HALT, press again -> one step pulse.

Source files
------------

// File: rtl/logic_clock_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// logic_clock_ctrl_pkg
// Shared definitions for the CP clock-control slice.
//   ctrlState_t : controller states (STOP, RUN, STEP_H, STEP_L)
//   SPEED_*     : rate-select codes driven on the SPEED input
// ---------------------------------------------------------------------------
package logic_clock_ctrl_pkg;

    typedef enum logic [1:0] {
        STOP   = 2'd0,
        RUN    = 2'd1,
        STEP_H = 2'd2,
        STEP_L = 2'd3
    } ctrlState_t;

    localparam logic [1:0] SPEED_1HZ   = 2'd0;
    localparam logic [1:0] SPEED_10HZ  = 2'd1;
    localparam logic [1:0] SPEED_100HZ = 2'd2;
    localparam logic [1:0] SPEED_1MHZ  = 2'd3;

endpackage

// File: rtl/logic_clock_ctrl_debounce.sv
// ---------------------------------------------------------------------------
// logic_debounce
// Two-flop synchroniser followed by a stable-count filter. The filtered
// level only follows the synchronised input after it has disagreed with
// the current level for DEB_CYC consecutive clocks.
// Ports:
//   clk   : system clock
//   rstN  : asynchronous active-low reset (level resets to 0)
//   rawIn : asynchronous, possibly bouncing input
//   level : debounced level
// ---------------------------------------------------------------------------
module logic_debounce #(
    parameter int unsigned DEB_CYC = 500000,
    parameter int unsigned CNT_W   = 25
) (
    input  logic clk,
    input  logic rstN,
    input  logic rawIn,
    output logic level
);

    logic             syncA;
    logic             syncB;
    logic [CNT_W-1:0] stableCnt;

    // Two-stage synchroniser to bring the raw input into the clock domain.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            syncA <= 1'b0;
            syncB <= 1'b0;
        end else begin
            syncA <= rawIn;
            syncB <= syncA;
        end
    end

    // Count consecutive cycles in which the synchronised input disagrees
    // with the accepted level; any agreeing cycle restarts the count.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            stableCnt <= '0;
            level     <= 1'b0;
        end else if (syncB != level) begin
            if (stableCnt == CNT_W'(DEB_CYC - 1)) begin
                level     <= syncB;
                stableCnt <= '0;
            end else begin
                stableCnt <= stableCnt + CNT_W'(1);
            end
        end else begin
            stableCnt <= '0;
        end
    end

endmodule

// File: rtl/logic_clock_ctrl.sv
// ---------------------------------------------------------------------------
// logic_clock_ctrl
// Generates the emulated CP clock for the 74HC191 counter chain: free-run at
// one of four rates, halt, or debounced single-step. CP and its edge strobes
// are registered so the strobe appears in the same cycle as the new CP value.
// Ports:
//   CLK      : system clock
//   nRST     : asynchronous active-low reset
//   RUN_SW   : raw run/stop switch (1 = run)
//   STEP_BTN : raw step button (1 = pressed)
//   HALT     : synchronous halt request, level
//   SPEED    : rate select, sampled only when the phase counter reloads
//   CP       : emulated clock
//   CP_RISE  : one-cycle strobe when CP goes 0->1
//   CP_FALL  : one-cycle strobe when CP goes 1->0
//   RUNNING  : high while in the RUN state
// ---------------------------------------------------------------------------
module logic_clock_ctrl
    import logic_clock_ctrl_pkg::*;
#(
    parameter int unsigned DEB_CYC = 500000,
    parameter int unsigned HALF0   = 25000000,
    parameter int unsigned HALF1   = 2500000,
    parameter int unsigned HALF2   = 250000,
    parameter int unsigned HALF3   = 25,
    parameter int unsigned STEP_HI = 4,
    parameter int unsigned CNT_W   = 25
) (
    input  logic       CLK,
    input  logic       nRST,
    input  logic       RUN_SW,
    input  logic       STEP_BTN,
    input  logic       HALT,
    input  logic [1:0] SPEED,
    output logic       CP,
    output logic       CP_RISE,
    output logic       CP_FALL,
    output logic       RUNNING
);

    logic             runDb;
    logic             stepDb;
    logic             stepDbPrev;
    logic             stepEvt;
    logic             stopReq;
    ctrlState_t       state;
    ctrlState_t       stateNext;
    logic [CNT_W-1:0] phase;
    logic [CNT_W-1:0] phaseNext;
    logic [CNT_W-1:0] halfLoad;
    logic             cpNext;
    logic             riseNext;
    logic             fallNext;
    logic             runningNext;

    logic_debounce #(.DEB_CYC(DEB_CYC), .CNT_W(CNT_W)) runDebounce (
        .clk   (CLK),
        .rstN  (nRST),
        .rawIn (RUN_SW),
        .level (runDb)
    );

    logic_debounce #(.DEB_CYC(DEB_CYC), .CNT_W(CNT_W)) stepDebounce (
        .clk   (CLK),
        .rstN  (nRST),
        .rawIn (STEP_BTN),
        .level (stepDb)
    );

    // Remember the previous debounced step level so each press yields a
    // single one-cycle step event.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stepDbPrev <= 1'b0;
        end else begin
            stepDbPrev <= stepDb;
        end
    end

    assign stepEvt = stepDb & ~stepDbPrev;
    assign stopReq = ~runDb | HALT;

    // Phase reload value for the currently selected rate; only consulted at
    // the moment of a reload, so a SPEED change never stretches a half-period.
    always_comb begin
        halfLoad = CNT_W'(HALF3 - 1);
        case (SPEED)
            SPEED_1HZ:   halfLoad = CNT_W'(HALF0 - 1);
            SPEED_10HZ:  halfLoad = CNT_W'(HALF1 - 1);
            SPEED_100HZ: halfLoad = CNT_W'(HALF2 - 1);
            SPEED_1MHZ:  halfLoad = CNT_W'(HALF3 - 1);
            default:     halfLoad = CNT_W'(HALF3 - 1);
        endcase
    end

    // State register; CP, its strobes and RUNNING are registered here too.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state   <= STOP;
            phase   <= '0;
            CP      <= 1'b0;
            CP_RISE <= 1'b0;
            CP_FALL <= 1'b0;
            RUNNING <= 1'b0;
        end else begin
            state   <= stateNext;
            phase   <= phaseNext;
            CP      <= cpNext;
            CP_RISE <= riseNext;
            CP_FALL <= fallNext;
            RUNNING <= runningNext;
        end
    end

    // Next-state logic. A stop request while CP is low leaves RUN at once;
    // while CP is high the pulse is finished and RUN is left on the fall.
    always_comb begin
        stateNext = state;
        phaseNext = phase;
        case (state)
            STOP: begin
                if (runDb && !HALT) begin
                    stateNext = RUN;
                    phaseNext = halfLoad;
                end else if (stepEvt && !HALT) begin
                    stateNext = STEP_H;
                    phaseNext = CNT_W'(STEP_HI - 1);
                end
            end
            RUN: begin
                if (!CP && stopReq) begin
                    stateNext = STOP;
                    phaseNext = '0;
                end else if (phase == '0) begin
                    if (CP && stopReq) begin
                        stateNext = STOP;
                        phaseNext = '0;
                    end else begin
                        phaseNext = halfLoad;
                    end
                end else begin
                    phaseNext = phase - CNT_W'(1);
                end
            end
            STEP_H: begin
                if (phase == '0) begin
                    stateNext = STEP_L;
                    phaseNext = CNT_W'(STEP_HI - 1);
                end else begin
                    phaseNext = phase - CNT_W'(1);
                end
            end
            STEP_L: begin
                if (phase == '0) begin
                    stateNext = STOP;
                end else begin
                    phaseNext = phase - CNT_W'(1);
                end
            end
            default: begin
                stateNext = STOP;
                phaseNext = '0;
            end
        endcase
    end

    // Output logic: derive the next CP level from the transition being
    // taken, then the strobes from the change in CP.
    always_comb begin
        cpNext = CP;
        case (state)
            STOP: begin
                if (stateNext == STEP_H) begin
                    cpNext = 1'b1;
                end
            end
            RUN: begin
                if (stateNext == STOP) begin
                    cpNext = 1'b0;
                end else if (phase == '0) begin
                    cpNext = ~CP;
                end
            end
            STEP_H: begin
                if (phase == '0) begin
                    cpNext = 1'b0;
                end
            end
            default: cpNext = CP;
        endcase
        riseNext    = cpNext & ~CP;
        fallNext    = ~cpNext & CP;
        runningNext = (stateNext == RUN);
    end

endmodule

// File: tb/tb_logic_clock_ctrl.sv
// ---------------------------------------------------------------------------
// tb_logic_clock_ctrl
// Self-checking bench for logic_clock_ctrl with shortened timing constants.
// A reference model tracks CP as a sequence of scheduled edges and the
// debounced inputs as windows over the raw input history.
// ---------------------------------------------------------------------------
module tb_logic_clock_ctrl;

    localparam int DEB = 4;
    localparam int H0  = 9;
    localparam int H1  = 7;
    localparam int H2  = 5;
    localparam int H3  = 3;
    localparam int SHI = 2;
    localparam int CW  = 8;

    localparam int M_IDLE   = 0;
    localparam int M_RUN    = 1;
    localparam int M_STEPHI = 2;
    localparam int M_STEPLO = 3;

    typedef struct {
        logic       runSw;
        logic       stepBtn;
        logic       halt;
        logic [1:0] speed;
        logic       cp;
        logic       rise;
        logic       fall;
        logic       running;
    } vec_t;

    logic       CLK = 1'b0;
    logic       nRST;
    logic       RUN_SW;
    logic       STEP_BTN;
    logic       HALT;
    logic [1:0] SPEED;
    logic       CP;
    logic       CP_RISE;
    logic       CP_FALL;
    logic       RUNNING;

    int testsRun    = 0;
    int testsFailed = 0;

    int mCyc;
    int mMode;
    int mEdgeAt;
    bit mCp;
    bit mRise;
    bit mFall;
    bit mRunLvl;
    bit mStepLvl;
    bit mStepPrev;
    bit runHist[$];
    bit stepHist[$];

    vec_t vecs[20];

    logic_clock_ctrl #(
        .DEB_CYC (DEB),
        .HALF0   (H0),
        .HALF1   (H1),
        .HALF2   (H2),
        .HALF3   (H3),
        .STEP_HI (SHI),
        .CNT_W   (CW)
    ) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .RUN_SW   (RUN_SW),
        .STEP_BTN (STEP_BTN),
        .HALT     (HALT),
        .SPEED    (SPEED),
        .CP       (CP),
        .CP_RISE  (CP_RISE),
        .CP_FALL  (CP_FALL),
        .RUNNING  (RUNNING)
    );

    // 100 MHz-style free-running clock.
    always #5 CLK = ~CLK;

    // Hard stop in case something upstream never returns.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required earlier finish");
        $fatal(1, "[TB] watchdog");
    end

    function automatic int halfOf(input logic [1:0] s);
        case (s)
            2'd0:    return H0;
            2'd1:    return H1;
            2'd2:    return H2;
            default: return H3;
        endcase
    endfunction

    function automatic vec_t mkVec(input logic cp, input logic rise, input logic fall,
                                   input logic running);
        vec_t v;
        v.runSw   = 1'b1;
        v.stepBtn = 1'b0;
        v.halt    = 1'b0;
        v.speed   = 2'd3;
        v.cp      = cp;
        v.rise    = rise;
        v.fall    = fall;
        v.running = running;
        return v;
    endfunction

    task automatic modelReset();
        mCyc      = 0;
        mMode     = M_IDLE;
        mEdgeAt   = 0;
        mCp       = 1'b0;
        mRise     = 1'b0;
        mFall     = 1'b0;
        mRunLvl   = 1'b0;
        mStepLvl  = 1'b0;
        mStepPrev = 1'b0;
        runHist.delete();
        stepHist.delete();
        for (int i = 0; i < DEB + 2; i++) begin
            runHist.push_back(1'b0);
            stepHist.push_back(1'b0);
        end
    endtask

    // Advance the model by one clock edge using the inputs present at it.
    task automatic modelStep();
        bit evt;
        bit stopNow;
        bit prevCp;
        bit allDiff;
        mCyc++;
        evt     = mStepLvl && !mStepPrev;
        stopNow = !mRunLvl || HALT;
        prevCp  = mCp;
        case (mMode)
            M_IDLE: begin
                if (mRunLvl && !HALT) begin
                    mMode   = M_RUN;
                    mEdgeAt = mCyc + halfOf(SPEED);
                end else if (evt && !HALT) begin
                    mMode   = M_STEPHI;
                    mCp     = 1'b1;
                    mEdgeAt = mCyc + SHI;
                end
            end
            M_RUN: begin
                if (!mCp && stopNow) begin
                    mMode = M_IDLE;
                end else if (mCyc == mEdgeAt) begin
                    mCp = !mCp;
                    if (!mCp && stopNow) mMode = M_IDLE;
                    else mEdgeAt = mCyc + halfOf(SPEED);
                end
            end
            M_STEPHI: begin
                if (mCyc == mEdgeAt) begin
                    mCp     = 1'b0;
                    mMode   = M_STEPLO;
                    mEdgeAt = mCyc + SHI;
                end
            end
            M_STEPLO: begin
                if (mCyc == mEdgeAt) mMode = M_IDLE;
            end
            default: mMode = M_IDLE;
        endcase
        mRise     = mCp && !prevCp;
        mFall     = !mCp && prevCp;
        mStepPrev = mStepLvl;
        runHist.push_front(RUN_SW);
        void'(runHist.pop_back());
        stepHist.push_front(STEP_BTN);
        void'(stepHist.pop_back());
        // Entries 2..DEB+1 are what the synchroniser has delivered over the
        // last DEB cycles; all disagreeing with the level flips it.
        allDiff = 1'b1;
        for (int j = 2; j < DEB + 2; j++) if (runHist[j] == mRunLvl) allDiff = 1'b0;
        if (allDiff) mRunLvl = !mRunLvl;
        allDiff = 1'b1;
        for (int j = 2; j < DEB + 2; j++) if (stepHist[j] == mStepLvl) allDiff = 1'b0;
        if (allDiff) mStepLvl = !mStepLvl;
    endtask

    task automatic checkVal(input string name, input int actual, input int expected);
        testsRun++;
        if (actual != expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkOutput(input string name);
        testsRun++;
        if (CP !== mCp || CP_RISE !== mRise || CP_FALL !== mFall ||
            RUNNING !== (mMode == M_RUN)) begin
            testsFailed++;
            $display("[TB] FAIL %s @cyc %0d: got cp=%b rise=%b fall=%b running=%b, expected cp=%b rise=%b fall=%b running=%b",
                     name, mCyc, CP, CP_RISE, CP_FALL, RUNNING,
                     mCp, mRise, mFall, (mMode == M_RUN));
        end
    endtask

    task automatic applyStimulus(input logic runSw, input logic stepBtn, input logic halt,
                                 input logic [1:0] speed);
        RUN_SW   = runSw;
        STEP_BTN = stepBtn;
        HALT     = halt;
        SPEED    = speed;
    endtask

    // One clock: model follows the edge, outputs sampled on the falling edge.
    task automatic cycle();
        @(posedge CLK);
        modelStep();
        @(negedge CLK);
        checkOutput("model");
    endtask

    task automatic waitRise(input int limit, input string name);
        bit found;
        found = 1'b0;
        for (int i = 0; i < limit; i++) begin
            cycle();
            if (CP_RISE === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        checkVal(name, int'(found), 1);
    endtask

    task automatic doReset();
        nRST = 1'b0;
        repeat (2) @(negedge CLK);
        checkVal("reset outputs", int'({CP, CP_RISE, CP_FALL, RUNNING}), 0);
        nRST = 1'b1;
        modelReset();
    endtask

    initial begin
        int hi;
        int lo;
        int rises;
        int falls;
        int hiMax;
        logic stepPat[5];

        // Bring-up vectors after reset with RUN_SW=1, SPEED=3.
        for (int i = 0; i < 6; i++) vecs[i] = mkVec(1'b0, 1'b0, 1'b0, 1'b0);
        vecs[6]  = mkVec(1'b0, 1'b0, 1'b0, 1'b1);
        vecs[7]  = mkVec(1'b0, 1'b0, 1'b0, 1'b1);
        vecs[8]  = mkVec(1'b0, 1'b0, 1'b0, 1'b1);
        vecs[9]  = mkVec(1'b1, 1'b1, 1'b0, 1'b1);
        vecs[10] = mkVec(1'b1, 1'b0, 1'b0, 1'b1);
        vecs[11] = mkVec(1'b1, 1'b0, 1'b0, 1'b1);
        vecs[12] = mkVec(1'b0, 1'b0, 1'b1, 1'b1);
        vecs[13] = mkVec(1'b0, 1'b0, 1'b0, 1'b1);
        vecs[14] = mkVec(1'b0, 1'b0, 1'b0, 1'b1);
        vecs[15] = mkVec(1'b1, 1'b1, 1'b0, 1'b1);
        vecs[16] = mkVec(1'b1, 1'b0, 1'b0, 1'b1);
        vecs[17] = mkVec(1'b1, 1'b0, 1'b0, 1'b1);
        vecs[18] = mkVec(1'b0, 1'b0, 1'b1, 1'b1);
        vecs[19] = mkVec(1'b0, 1'b0, 1'b0, 1'b1);

        applyStimulus(1'b0, 1'b0, 1'b0, 2'd3);
        modelReset();
        @(negedge CLK);
        doReset();

        for (int i = 0; i < 20; i++) begin
            applyStimulus(vecs[i].runSw, vecs[i].stepBtn, vecs[i].halt, vecs[i].speed);
            cycle();
            checkVal($sformatf("vec %0d", i), int'({CP, CP_RISE, CP_FALL, RUNNING}),
                     int'({vecs[i].cp, vecs[i].rise, vecs[i].fall, vecs[i].running}));
        end

        // HALT one cycle after a rise: the high phase still lasts H3 cycles.
        waitRise(20, "halt wait rise");
        applyStimulus(1'b1, 1'b0, 1'b1, 2'd3);
        hi = 1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (CP) hi++;
            else break;
        end
        checkVal("halt high time", hi, H3);
        checkVal("halt fall strobe", int'(CP_FALL), 1);
        checkVal("halt running", int'(RUNNING), 0);
        rises = 0;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (CP_RISE) rises++;
        end
        checkVal("halt no rises", rises, 0);

        // SPEED 3->2 during a high phase: current phase keeps H3, next uses H2.
        applyStimulus(1'b1, 1'b0, 1'b0, 2'd3);
        waitRise(30, "speed wait rise");
        applyStimulus(1'b1, 1'b0, 1'b0, 2'd2);
        hi = 1;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (CP) hi++;
            else break;
        end
        checkVal("speed old high", hi, H3);
        lo = 1;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (!CP) lo++;
            else break;
        end
        checkVal("speed new low", lo, H2);
        hi = 1;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (CP) hi++;
            else break;
        end
        checkVal("speed new high", hi, H2);

        // Asynchronous reset in the middle of a high phase.
        waitRise(30, "reset wait rise");
        cycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 2'd3);
        #2;
        nRST = 1'b0;
        #1;
        checkVal("async reset outputs", int'({CP, CP_RISE, CP_FALL, RUNNING}), 0);
        #1;
        nRST = 1'b1;
        modelReset();
        for (int i = 0; i < 8; i++) cycle();
        checkVal("after reset running", int'(RUNNING), 0);

        // Bouncy step press with RUN off: exactly one 2-cycle CP pulse.
        stepPat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        rises = 0; falls = 0; hi = 0; hiMax = 0;
        for (int i = 0; i < 27; i++) begin
            if (i < 5) applyStimulus(1'b0, stepPat[i], 1'b0, 2'd3);
            else if (i < 15) applyStimulus(1'b0, 1'b1, 1'b0, 2'd3);
            else applyStimulus(1'b0, 1'b0, 1'b0, 2'd3);
            cycle();
            if (CP_RISE) rises++;
            if (CP_FALL) falls++;
            if (CP) hi++;
            else hi = 0;
            if (hi > hiMax) hiMax = hi;
        end
        checkVal("step rises", rises, 1);
        checkVal("step falls", falls, 1);
        checkVal("step high time", hiMax, SHI);

        // Step while halted is ignored; after HALT drops a press steps once.
        rises = 0;
        applyStimulus(1'b0, 1'b1, 1'b1, 2'd3);
        repeat (10) cycle();
        applyStimulus(1'b0, 1'b0, 1'b1, 2'd3);
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (CP_RISE || CP) rises++;
        end
        checkVal("halted step activity", rises, 0);
        rises = 0;
        applyStimulus(1'b0, 1'b1, 1'b0, 2'd3);
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (CP_RISE) rises++;
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 2'd3);
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (CP_RISE) rises++;
        end
        checkVal("released step rises", rises, 1);

        // Randomised run: slow switch/halt changes, bouncy button, speed churn.
        for (int i = 0; i < 2500; i++) begin
            logic r, s, h;
            logic [1:0] sp;
            r  = RUN_SW;
            s  = STEP_BTN;
            h  = HALT;
            sp = SPEED;
            if ($urandom_range(59, 0) == 0) r = ~r;
            if ($urandom_range(3, 0) == 0) s = ~s;
            if ($urandom_range(39, 0) == 0) h = ~h;
            if ($urandom_range(19, 0) == 0) sp = 2'($urandom_range(3, 0));
            applyStimulus(r, s, h, sp);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
